fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Parametrised forwarding and load-use hazard controller for the RISC-V pipeline; successor to the fixed 2-stage forwarding unit.
//  Owns a shift register of in-flight destination tags (EX, MEM, WB, ...), computes per-operand forward selects for the EX stage,
//  and generates the ID stall for load-use hazards with configurable load latency. Sits beside the ID/EX register; drives EX operand muxes.
// PARAMETERS
//  REG_ADDR_W  5  register index width (x0 hard-wired zero)
//  NUM_SRC     2  source operands per instruction (3 for fused/FMA variants)
//  FWD_STAGES  2  forwarding slots after EX (slot1=EX/MEM, slot2=MEM/WB, ...); must be >= LOAD_LAT+1
//  LOAD_LAT    1  slots a load result lags an ALU result; load data forwardable from slot LOAD_LAT+1 onward
//  SEL_W       $clog2(FWD_STAGES+1)  derived; width of one forward select
// PORTS
//  clk           in   1                    pipeline clock, rising edge
//  rst_n         in   1                    asynchronous active-low reset
//  id_valid      in   1                    ID holds a real instruction
//  id_rs         in   NUM_SRC*REG_ADDR_W   ID source indices, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
//  id_rs_used    in   NUM_SRC              operand i actually read (masks false hazards: LUI, JAL, ...)
//  id_rd         in   REG_ADDR_W           ID destination index
//  id_regwrite   in   1                    ID instruction writes rd
//  id_memread    in   1                    ID instruction is a load
//  ex_flush      in   1                    branch/jump redirect resolved in EX; kills ID instruction
//  stall_id      out  1                    hold PC and IF/ID, insert bubble into EX
//  ex_valid      out  1                    EX slot holds a real instruction
//  fwd_sel       out  NUM_SRC*SEL_W        per EX operand: 0=regfile, k=result of slot k
//  stall_cycles  out  32                   saturating count of cycles with stall_id=1
// BEHAVIOUR
//  State: slots 0..FWD_STAGES, each {valid, rd, regwrite, memread}; slot0 (EX) also holds rs[NUM_SRC], rs_used.
//  Reset (async, rst_n=0): all slot valid=0, stall_cycles=0; hence stall_id=0, ex_valid=0, fwd_sel=0. Takes effect mid-stream; in-flight tags discarded.
//  Each rising edge: slot k <= slot k-1 for k>=1, always (later stages never stall here).
//   slot0 <= ID fields with valid=id_valid, unless ex_flush or stall_id -> slot0.valid <= 0 (bubble).
//  Write-back occurs at slot FWD_STAGES; register file is write-first, so nothing older needs forwarding.
//  match(k,i) = slot k valid & regwrite & rd!=0 & rd==slot0.rs[i] & slot0.rs_used[i] & slot0.valid.
//  fwd_sel[i] = lowest k in 1..FWD_STAGES with match(k,i) (youngest producer wins); 0 if none. Combinational from state only.
//   Loads in slots 1..LOAD_LAT never match here: stall guarantees the case cannot arise; RTL also masks it explicitly.
//  stall_id = id_valid & !ex_flush & exists i,j: id_rs_used[i] & id_rs[i]!=0 & slot j valid & memread & rd==id_rs[i], j in 0..LOAD_LAT-1.
//   Stall self-terminates: bubble advances the load; stall lasts LOAD_LAT-j cycles.
//  Simultaneous ex_flush and stall condition: flush wins, stall_id=0, slot0 gets bubble.
//  id_rs==0 or rs_used=0 never stalls nor forwards; rd==0 producer never forwards.
//  stall_cycles increments on each edge with stall_id=1; holds at 32'hFFFF_FFFF.
//  Elaboration check: FWD_STAGES < LOAD_LAT+1 -> $error.
// STRUCTURE
//  Shared package riscv_pipe_pkg: slot struct (valid, rd, regwrite, memread), REG_ADDR_W default, FWD_SEL_W function.
//  Sub-module fwd_prio_match: one operand's priority encoder over FWD_STAGES slots -> SEL_W select; generate NUM_SRC copies.
//  Slot shift register, stall detection and counter live in top level.
// TESTING
//  Defaults. add x5 then add x6,x5,x1 back-to-back -> second in EX: fwd_sel[0]=1, fwd_sel[1]=0, no stall.
//  add x5; nop; sub x7,x1,x5 -> sub in EX: fwd_sel[1]=2; repeat with x5 written in slots 1 and 2 -> sel=1 (youngest wins).
//  lw x5; add x6,x5,x5 -> stall_id=1 exactly 1 cycle, bubble in EX, then fwd_sel=2/2; stall_cycles=1.
//  LOAD_LAT=2, FWD_STAGES=3: lw x8; add x9,x8,x0 -> 2 stall cycles, then fwd_sel[0]=3; with one nop between -> 1 stall.
//  Writes to x0, and lui x5 (rs_used=0) after lw x5 -> no forward, no stall; ex_flush with load-use pending -> stall_id=0, EX bubble.
//  rst_n low mid-stall for 1 cycle -> stall_id, ex_valid, fwd_sel drop immediately (async); stall_cycles=0 after release.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline slot type and forwarding-select sizing helpers.
package riscv_pipe_pkg;
    localparam int DEF_REG_ADDR_W = 5;
    // Slot tags are stored at a fixed maximum width; narrower register indices are zero-extended.
    localparam int MAX_REG_ADDR_W = 8;

    typedef struct packed {
        logic                      valid;
        logic [MAX_REG_ADDR_W-1:0] rd;
        logic                      regwrite;
        logic                      memread;
    } slot_t;

    function automatic int FWD_SEL_W(input int stages);
        return $clog2(stages + 1);
    endfunction
endpackage

// File: rtl/fwd_prio_match.sv
// fwd_prio_match: priority encoder picking the youngest matching forwarding slot for one operand.
module fwd_prio_match #(
    parameter int FWD_STAGES = 2,
    parameter int SEL_W      = 2
) (
    input  logic [FWD_STAGES-1:0] hit,
    output logic [SEL_W-1:0]      sel
);
    // Walk oldest to youngest so the lowest slot index is assigned last and wins.
    always_comb begin
        sel = '0;
        for (int k = FWD_STAGES; k >= 1; k--)
            if (hit[k-1]) sel = SEL_W'(k);
    end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: in-flight destination tag pipeline, EX operand forward selects and load-use ID stall.
module fwd_hazard_ctrl import riscv_pipe_pkg::*; #(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = FWD_SEL_W(FWD_STAGES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    input  logic                          ex_flush,
    output logic                          stall_id,
    output logic                          ex_valid,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic [31:0]                   stall_cycles
);
    typedef logic [MAX_REG_ADDR_W-1:0] tag_t;

    slot_t                              slots [FWD_STAGES+1];
    logic [NUM_SRC*REG_ADDR_W-1:0]      exRs;
    logic [NUM_SRC-1:0]                 exRsUsed;
    logic                               loadUse;
    logic [NUM_SRC-1:0][FWD_STAGES-1:0] hit;

    if (FWD_STAGES < LOAD_LAT + 1) begin : gBadStages
        $error("fwd_hazard_ctrl: FWD_STAGES must be >= LOAD_LAT+1");
    end
    if (REG_ADDR_W > MAX_REG_ADDR_W) begin : gBadWidth
        $error("fwd_hazard_ctrl: REG_ADDR_W exceeds MAX_REG_ADDR_W");
    end

    function automatic tag_t srcTag(input logic [NUM_SRC*REG_ADDR_W-1:0] rs, input int i);
        return tag_t'(rs[i*REG_ADDR_W +: REG_ADDR_W]);
    endfunction

    always_comb begin
        loadUse = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int j = 0; j < LOAD_LAT; j++)
                if (id_rs_used[i] && srcTag(id_rs, i) != '0 && slots[j].valid &&
                    slots[j].memread && slots[j].rd == srcTag(id_rs, i))
                    loadUse = 1'b1;
    end

    assign stall_id = id_valid & ~ex_flush & loadUse;
    assign ex_valid = slots[0].valid;

    // Loads still inside their latency window are never forwardable.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int k = 1; k <= FWD_STAGES; k++)
                hit[i][k-1] = slots[0].valid && exRsUsed[i] && slots[k].valid && slots[k].regwrite &&
                              slots[k].rd != '0 && slots[k].rd == srcTag(exRs, i) &&
                              !(slots[k].memread && k <= LOAD_LAT);
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g
        fwd_prio_match #(.FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) uMatch (
            .hit(hit[i]),
            .sel(fwd_sel[i*SEL_W +: SEL_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= FWD_STAGES; k++) slots[k] <= '0;
            exRs         <= '0;
            exRsUsed     <= '0;
            stall_cycles <= '0;
        end else begin
            slots[0] <= '{valid: id_valid & ~ex_flush & ~stall_id, rd: tag_t'(id_rd),
                          regwrite: id_regwrite, memread: id_memread};
            for (int k = 1; k <= FWD_STAGES; k++) slots[k] <= slots[k-1];
            exRs     <= id_rs;
            exRsUsed <= id_rs_used;
            if (stall_id && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed instruction sequences against default and LOAD_LAT=2 controllers.
module tb_fwd_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_regwrite, id_memread, ex_flush;
    logic        stallA, exVA, stallB, exVB;
    logic [3:0]  selA, selB;
    logic [31:0] cntA, cntB;

    always #5 clk = ~clk;

    fwd_hazard_ctrl dutA (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .stall_id(stallA), .ex_valid(exVA), .fwd_sel(selA), .stall_cycles(cntA)
    );

    fwd_hazard_ctrl #(.FWD_STAGES(3), .LOAD_LAT(2)) dutB (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .stall_id(stallB), .ex_valid(exVB), .fwd_sel(selB), .stall_cycles(cntB)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] r1, r2;
        logic [1:0] used;
        logic [4:0] rd;
        logic       rw, mr;
    } ins_t;

    typedef struct {
        string      tag;
        logic       exV;
        logic [1:0] s0, s1;
    } exp_t;

    exp_t sb [$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   useB = 1'b0;

    localparam ins_t BUB = '0;
    function automatic ins_t fAlu(input logic [4:0] rd, r1, r2); return '{1'b1, r1, r2, 2'b11, rd, 1'b1, 1'b0}; endfunction
    function automatic ins_t fLd(input logic [4:0] rd, r1);      return '{1'b1, r1, 5'd0, 2'b01, rd, 1'b1, 1'b1}; endfunction
    function automatic ins_t fLui(input logic [4:0] rd);         return '{1'b1, 5'd0, 5'd0, 2'b00, rd, 1'b1, 1'b0}; endfunction
    function automatic ins_t fNop();                             return '{1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0}; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input ins_t in, input logic fl);
        id_valid    = in.v;
        id_rs       = {in.r2, in.r1};
        id_rs_used  = in.used;
        id_rd       = in.rd;
        id_regwrite = in.rw;
        id_memread  = in.mr;
        ex_flush    = fl;
    endtask

    // Called at a falling edge: checks the combinational stall, then the EX state after the next rising edge.
    task automatic cyc(input string tag, input ins_t in, input logic fl, input logic eStall,
                       input logic eV, input logic [1:0] e0, input logic [1:0] e1);
        exp_t e;
        drive(in, fl);
        #1 chk({tag, "_stall"}, 32'(useB ? stallB : stallA), 32'(eStall));
        sb.push_back('{tag, eV, e0, e1});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_exv"}, 32'(useB ? exVB : exVA), 32'(e.exV));
        chk({e.tag, "_sel"}, 32'(useB ? selB : selA), 32'({e.s1, e.s0}));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cyc("idle", BUB, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(BUB, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_stallA", 32'(stallA), 32'd0);
        chk("rst_exvA",   32'(exVA),   32'd0);
        chk("rst_selA",   32'(selA),   32'd0);
        chk("rst_cntA",   cntA,        32'd0);
        chk("rst_exvB",   32'(exVB),   32'd0);
        chk("rst_cntB",   cntB,        32'd0);
        rst_n = 1'b1;

        cyc("b2b_add5",  fAlu(5, 1, 2), 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("b2b_add6",  fAlu(6, 5, 1), 1'b0, 1'b0, 1'b1, 2'd1, 2'd0);
        idle(3);

        cyc("gap_add5",  fAlu(5, 1, 2), 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("gap_nop",   fNop(),        1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("gap_sub7",  fAlu(7, 1, 5), 1'b0, 1'b0, 1'b1, 2'd0, 2'd2);
        idle(3);

        cyc("yng_add5a", fAlu(5, 1, 2), 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("yng_add5b", fAlu(5, 1, 2), 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("yng_sub7",  fAlu(7, 1, 5), 1'b0, 1'b0, 1'b1, 2'd0, 2'd1);
        idle(3);

        cyc("lu_lw5",    fLd(5, 1),     1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("lu_stall",  fAlu(6, 5, 5), 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        cyc("lu_go",     fAlu(6, 5, 5), 1'b0, 1'b0, 1'b1, 2'd2, 2'd2);
        chk("lu_cntA", cntA, 32'd1);
        idle(3);

        cyc("lui_lw5",   fLd(5, 1),     1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("lui_x5",    fLui(5),       1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("x0_add",    fAlu(0, 1, 2), 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("x0_use",    fAlu(6, 0, 0), 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("x0_lw",     fLd(0, 1),     1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("x0_lwuse",  fAlu(6, 0, 1), 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        idle(3);

        cyc("fl_lw5",    fLd(5, 1),     1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("fl_kill",   fAlu(6, 5, 1), 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        chk("fl_cntA", cntA, 32'd1);
        idle(3);

        cyc("rl_lw5",    fLd(5, 1),     1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        drive(fAlu(6, 5, 5), 1'b0);
        #1 chk("rl_pre_stall", 32'(stallA), 32'd1);
        rst_n = 1'b0;
        #1 chk("rl_stall", 32'(stallA), 32'd0);
        chk("rl_exv", 32'(exVA), 32'd0);
        chk("rl_sel", 32'(selA), 32'd0);
        @(posedge clk);
        #1 chk("rl_hold_exv", 32'(exVA), 32'd0);
        @(negedge clk);
        drive(BUB, 1'b0);
        rst_n = 1'b1;
        #1 chk("rl_cntA", cntA, 32'd0);
        chk("rl_cntB", cntB, 32'd0);
        @(negedge clk);

        useB = 1'b1;
        idle(3);
        cyc("l2_lw8",    fLd(8, 1),     1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("l2_st1",    fAlu(9, 8, 0), 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        cyc("l2_st2",    fAlu(9, 8, 0), 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        cyc("l2_go",     fAlu(9, 8, 0), 1'b0, 1'b0, 1'b1, 2'd3, 2'd0);
        chk("l2_cntB", cntB, 32'd2);
        idle(3);
        cyc("l2n_lw8",   fLd(8, 1),     1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("l2n_nop",   fNop(),        1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cyc("l2n_st",    fAlu(9, 8, 0), 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        cyc("l2n_go",    fAlu(9, 8, 0), 1'b0, 1'b0, 1'b1, 2'd3, 2'd0);
        chk("l2n_cntB", cntB, 32'd3);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
